spi_peripheral: RTL
===================

Name: spi_peripheral

Overview:
- Responder (slave) end of the team's SPI link; pairs with the CPU-side mosi/miso initiator blocks.
- Receives W_DATA-bit words on mosi and returns W_DATA-bit words on miso, full duplex, MSB first, SPI mode 0 (CPOL=0, CPHA=0).
- Asynchronous SPI pins are synchronised into the clk domain.
- Word-level handshake toward local logic: a tx buffer plus an rx_valid pulse.

Parameters:
- W_DATA, default `W_CPU (32): word width in bits.
- W_CNT, default 5: bit-counter width; must satisfy 2^W_CNT >= W_DATA.
- SYNC_STAGES, default 2: synchroniser depth on sclk, cs_n and mosi.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- sclk  in  1  SPI clock from the initiator; asynchronous to clk.
- cs_n  in  1  chip select, active-low; asynchronous.
- mosi  in  1  serial data from the initiator.
- miso  out  1  serial data to the initiator.
- miso_oe  out  1  tri-state enable for miso; high while selected.
- tx_data  in  W_DATA  next word to return.
- tx_valid  in  1  offer of tx_data.
- tx_ready  out  1  tx buffer empty; transfer when tx_valid & tx_ready.
- rx_data  out  W_DATA  last complete received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- underrun  out  1  one-cycle pulse when a word starts with the tx buffer empty.

Behaviour:
- Reset (rst low, async): miso=0, miso_oe=0, rx_data=0, rx_valid=0, underrun=0, tx_ready=1, bit counter=0, shift registers=0, tx buffer empty, state IDLE.
- Timing constraint: sclk high and low phases each >= 4 clk periods. cs_n-fall to first sclk rise >= 4 clk periods. Faster sclk is out of spec and need not be handled.
- Synchronisation: SYNC_STAGES flops on sclk, cs_n and mosi, then one extra flop for edge detection. All actions below occur on the clk cycle after the synchronised edge is detected.
- State IDLE (cs_n high):
  - miso_oe=0, miso=0, counter held at 0.
  - Synchronised cs_n fall moves to XFER and performs a word start.
- Word start:
  - If the tx buffer is full, move it into tx_shift, mark the buffer empty, and raise tx_ready.
  - Otherwise load tx_shift with 0 and pulse underrun for one cycle.
  - miso = tx_shift MSB. miso_oe=1.
  - First miso bit is valid <= SYNC_STAGES+2 clk after cs_n falls.
- State XFER:
  - sclk rise:
    - rx_shift <= {rx_shift[W_DATA-2:0], mosi_sync}, counter++.
    - When the counter reaches W_DATA-1 before the increment: rx_data <= the new shifted value, rx_valid=1 for exactly one cycle, counter wraps to 0, and a pending word start is flagged.
  - sclk fall:
    - If a word start is pending, do the word start (back-to-back words under one cs_n).
    - Otherwise shift tx_shift left and drive the next bit on miso.
- cs_n rise (synchronised), from any point: return to IDLE.
  - A partial word is discarded: no rx_valid, rx_data unchanged, counter cleared.
  - The tx buffer is untouched; a word already moved to tx_shift is lost.
- tx handshake:
  - tx_ready is registered and equals buffer-empty.
  - tx_valid & tx_ready latches tx_data and drops tx_ready on the next cycle.
  - tx_valid while tx_ready=0 is ignored; the source must hold it.
  - A word start in the same cycle as a handshake sees the old state, i.e. an empty buffer, so underrun fires and the new word waits for the next word.
- Reset mid-transfer: everything returns to reset values immediately; the next transfer requires a fresh cs_n fall.
- sclk edges seen while cs_n is high are ignored.

Decomposition:
- Shared package/include: W_CPU (existing lib/opcodes.v), SPI mode constants, and state encodings IDLE=1'b0, XFER=1'b1.
- One sub-module: spi_sync_edge. It synchronises one async input through SYNC_STAGES flops and outputs the level plus rise and fall pulses. It is instantiated for sclk and cs_n; mosi uses level only.

Test Plan:
- Reset, then tx_data=32'hA5A5_0F0F loaded with tx_valid=1. cs_n low, 32 sclk cycles (sclk = clk/8) with mosi=32'hDEAD_BEEF -> miso serialises A5A50F0F MSB first, rx_data=DEADBEEF, one rx_valid pulse, tx_ready=1 after the word start.
- No tx word loaded, cs_n low, one word -> underrun pulses once, miso all zeros, rx_valid still pulses.
- Two words under one cs_n: buffer 32'h1111_1111, then refill with 32'h2222_2222 during word 1; mosi 32'h0000_0001 then 32'h8000_0000 -> miso returns 11111111 then 22222222, two rx_valid pulses with the matching rx_data values.
- cs_n rises after 13 bits -> no rx_valid, rx_data keeps its previous value, and the next full transfer receives correctly from bit 31.
- rst pulled low after 20 bits -> all outputs reach reset values within the same cycle, and the next transfer works from a fresh cs_n fall.
- tx_valid held while tx_ready=0 -> the word is not latched until tx_ready rises. sclk toggling with cs_n high -> no counter change and miso_oe stays 0.

Source files
------------

// File: rtl/spi_peripheral_pkg.sv
// Shared definitions for the SPI responder: data width, SPI mode and FSM state encoding.
package spi_peripheral_pkg;

   localparam int W_CPU        = 32;
   localparam int SYNC_DEFAULT = 2;

   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

endpackage

// File: rtl/spi_peripheral_sync.sv
// Synchroniser for one asynchronous SPI pin, with level plus one-cycle rise/fall pulses.
module spi_sync_edge
   import spi_peripheral_pkg::*;
#(
   parameter int   SYNC_STAGES = SYNC_DEFAULT,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // RESET_VAL matches the pin's idle level so releasing reset never fakes an edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q[0] <= async_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder: full-duplex MSB-first words with a one-deep tx buffer and rx_valid pulse.
module spi_peripheral
   import spi_peripheral_pkg::*;
#(
   parameter int W_DATA      = W_CPU,
   parameter int W_CNT       = 5,
   parameter int SYNC_STAGES = SYNC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [W_DATA-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [W_DATA-1:0] rx_data,
   output logic              rx_valid,
   output logic              underrun
);

   logic sclk_level_unused, sclk_rise, sclk_fall;
   logic cs_level, cs_rise_unused, cs_fall;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic mosi_sync;
   logic sample_edge, shift_edge, do_start;

   state_t              state;
   logic [W_CNT-1:0]    bit_cnt;
   logic [W_DATA-2:0]   rx_shift;
   logic [W_DATA-2:0]   tx_shift;
   logic [W_DATA-1:0]   tx_buf;
   logic                start_pending;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sclk_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (sclk),
      .level    (sclk_level_unused),
      .rise     (sclk_rise),
      .fall     (sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (cs_n),
      .level    (cs_level),
      .rise     (cs_rise_unused),
      .fall     (cs_fall)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mosi_q <= '0;
      end else begin
         mosi_q[0] <= mosi;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            mosi_q[i] <= mosi_q[i-1];
         end
      end
   end

   assign mosi_sync = mosi_q[SYNC_STAGES-1];

   // Modes 0 and 3 sample on the rising sclk edge, modes 1 and 2 on the falling one.
   assign sample_edge = (SPI_CPOL == SPI_CPHA) ? sclk_rise : sclk_fall;
   assign shift_edge  = (SPI_CPOL == SPI_CPHA) ? sclk_fall : sclk_rise;

   // A deselect seen in the same cycle as a shift edge wins, so no trailing word starts.
   always_comb begin
      do_start = 1'b0;
      if (state == IDLE) begin
         do_start = cs_fall;
      end else if (!cs_level) begin
         do_start = shift_edge & start_pending;
      end
   end

   // tx_ready doubles as the buffer-empty flag; a word start sees it before any same-cycle handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_buf   <= '0;
         tx_ready <= 1'b1;
      end else if (tx_valid && tx_ready) begin
         tx_buf   <= tx_data;
         tx_ready <= 1'b0;
      end else if (do_start && !tx_ready) begin
         tx_ready <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         rx_shift      <= '0;
         tx_shift      <= '0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         underrun      <= 1'b0;
         miso          <= 1'b0;
         miso_oe       <= 1'b0;
         start_pending <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         underrun <= 1'b0;
         case (state)
            IDLE: begin
               bit_cnt <= '0;
            end
            XFER: begin
               if (cs_level) begin
                  state         <= IDLE;
                  miso          <= 1'b0;
                  miso_oe       <= 1'b0;
                  bit_cnt       <= '0;
                  rx_shift      <= '0;
                  start_pending <= 1'b0;
               end else begin
                  if (sample_edge) begin
                     rx_shift <= {rx_shift[W_DATA-3:0], mosi_sync};
                     if (bit_cnt == W_CNT'(W_DATA - 1)) begin
                        rx_data       <= {rx_shift, mosi_sync};
                        rx_valid      <= 1'b1;
                        bit_cnt       <= '0;
                        start_pending <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + W_CNT'(1);
                     end
                  end
                  if (shift_edge && !start_pending) begin
                     miso     <= tx_shift[W_DATA-2];
                     tx_shift <= tx_shift << 1;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         // miso carries the word MSB directly; tx_shift holds the bits still to send.
         if (do_start) begin
            state         <= XFER;
            miso_oe       <= 1'b1;
            start_pending <= 1'b0;
            if (!tx_ready) begin
               miso     <= tx_buf[W_DATA-1];
               tx_shift <= tx_buf[W_DATA-2:0];
            end else begin
               miso     <= 1'b0;
               tx_shift <= '0;
               underrun <= 1'b1;
            end
         end
      end
   end

endmodule
